// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave bridging onto a single req/ack register port.
// One-deep AW/W/AR buffers, round-robin read/write arbitration, range decode and access timeout.
module axi_lite_reg_bridge #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           REG_ADDR_WIDTH = 4,
  parameter int unsigned           NUM_REGS       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      reg_req,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
  input  logic                      reg_ack,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_error
);

  localparam int unsigned STRB_W       = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT   = $clog2(STRB_W);
  localparam int unsigned WINDOW_BYTES = NUM_REGS * STRB_W;
  localparam int unsigned CNT_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]                state, state_nxt;
  logic                      ptr_rd, ptr_rd_nxt;
  logic                      aw_held, w_held, ar_held;
  logic [ADDR_WIDTH-1:0]     aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]     w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic                      grant_w, grant_r;
  logic                      write_rdy, read_rdy;
  logic                      kind_we, kind_we_nxt;
  logic [1:0]                resp_q, resp_nxt;
  logic [DATA_WIDTH-1:0]     rd_q, rd_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      req_nxt, we_nxt;
  logic [REG_ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0]     wdata_nxt, rdata_nxt;
  logic [STRB_W-1:0]         wstrb_nxt;
  logic                      bvalid_nxt, rvalid_nxt;
  logic [1:0]                bresp_nxt, rresp_nxt;

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // Offset is computed with a borrow bit so addresses below the base fall out of range.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < ADDR_WIDTH'(WINDOW_BYTES));
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return REG_ADDR_WIDTH'(off >> BYTE_SHIFT);
  endfunction

  assign awready   = !aw_held;
  assign wready    = !w_held;
  assign arready   = !ar_held;
  assign write_rdy = aw_held && w_held && !bvalid;
  assign read_rdy  = ar_held && !rvalid;

  // Channel holding registers; a held flag clears on the edge its transaction is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      ar_held   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (awvalid && !aw_held) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end else if (grant_w) begin
        aw_held <= 1'b0;
      end
      if (wvalid && !w_held) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (grant_w) begin
        w_held <= 1'b0;
      end
      if (arvalid && !ar_held) begin
        ar_held   <= 1'b1;
        ar_addr_q <= araddr;
      end else if (grant_r) begin
        ar_held <= 1'b0;
      end
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_nxt   = state;
    ptr_rd_nxt  = ptr_rd;
    grant_w     = 1'b0;
    grant_r     = 1'b0;
    kind_we_nxt = kind_we;
    resp_nxt    = resp_q;
    rd_nxt      = rd_q;
    cnt_nxt     = cnt;
    req_nxt     = reg_req;
    we_nxt      = reg_we;
    addr_nxt    = reg_addr;
    wdata_nxt   = reg_wdata;
    wstrb_nxt   = reg_wstrb;
    bvalid_nxt  = bvalid && !bready;
    bresp_nxt   = bresp;
    rvalid_nxt  = rvalid && !rready;
    rresp_nxt   = rresp;
    rdata_nxt   = rdata;

    case (state)
      ST_IDLE: begin
        if (write_rdy && (!read_rdy || !ptr_rd)) begin
          grant_w = 1'b1;
        end else if (read_rdy) begin
          grant_r = 1'b1;
        end
        if (write_rdy && read_rdy) begin
          ptr_rd_nxt = !ptr_rd;
        end
        if (grant_w) begin
          kind_we_nxt = 1'b1;
          if (in_window(aw_addr_q)) begin
            state_nxt = ST_ACCESS;
            req_nxt   = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = word_idx(aw_addr_q);
            wdata_nxt = w_data_q;
            wstrb_nxt = w_strb_q;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_RESP;
            resp_nxt  = RESP_DECERR;
          end
        end else if (grant_r) begin
          kind_we_nxt = 1'b0;
          if (in_window(ar_addr_q)) begin
            state_nxt = ST_ACCESS;
            req_nxt   = 1'b1;
            we_nxt    = 1'b0;
            addr_nxt  = word_idx(ar_addr_q);
            wstrb_nxt = '0;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_RESP;
            resp_nxt  = RESP_DECERR;
            rd_nxt    = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (reg_ack) begin
          state_nxt = ST_RESP;
          req_nxt   = 1'b0;
          resp_nxt  = reg_error ? RESP_SLVERR : RESP_OKAY;
          rd_nxt    = reg_error ? '0 : reg_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_nxt = ST_RESP;
          req_nxt   = 1'b0;
          resp_nxt  = RESP_SLVERR;
          rd_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        if (kind_we) begin
          bvalid_nxt = 1'b1;
          bresp_nxt  = resp_q;
        end else begin
          rvalid_nxt = 1'b1;
          rresp_nxt  = resp_q;
          rdata_nxt  = rd_q;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any in-flight access without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr_rd    <= 1'b0;
      kind_we   <= 1'b0;
      resp_q    <= RESP_OKAY;
      rd_q      <= '0;
      cnt       <= '0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      rvalid    <= 1'b0;
      rresp     <= RESP_OKAY;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      ptr_rd    <= ptr_rd_nxt;
      kind_we   <= kind_we_nxt;
      resp_q    <= resp_nxt;
      rd_q      <= rd_nxt;
      cnt       <= cnt_nxt;
      reg_req   <= req_nxt;
      reg_we    <= we_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_wstrb <= wstrb_nxt;
      bvalid    <= bvalid_nxt;
      bresp     <= bresp_nxt;
      rvalid    <= rvalid_nxt;
      rresp     <= rresp_nxt;
      rdata     <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge: latency, buffering, decode error, timeout, arbitration, reset.
module tb_axi_lite_reg_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        reg_req;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        reg_error;

  logic        ack_en;
  logic        ack_auto;
  logic        late_ack;
  logic        err_en;
  int          n_checks;
  int          n_pass;
  int          n_fail;
  int          req_cycles;
  int          grant_n;
  logic        grant_we [0:63];
  logic        req_q;

  axi_lite_reg_bridge dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_error(reg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reg_ack   = ack_auto | late_ack;
  assign reg_error = err_en;

  // Register-port responder: zero-wait ack when enabled, read data tagged with the word index.
  always @(negedge clk) begin
    ack_auto  = reg_req && ack_en;
    reg_rdata = 32'hC0DE_0000 | 32'(reg_addr);
  end

  // Counts request-high cycles and logs the kind of each new access.
  always @(posedge clk) begin
    if (reg_req) req_cycles++;
    if (reg_req && !req_q) begin
      grant_we[grant_n[5:0]] = reg_we;
      grant_n++;
    end
    req_q = reg_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin : main
    int   b0;
    int   g0;
    logic [7:0] exp_order;

    n_checks = 0; n_pass = 0; n_fail = 0;
    req_cycles = 0; grant_n = 0; req_q = 1'b0;
    ack_auto = 1'b0; reg_rdata = '0;
    rst = 1'b1; ack_en = 1'b1; late_ack = 1'b0; err_en = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_reg_req", reg_req, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_resps", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_reg_fields", {reg_addr, reg_wdata, reg_wstrb}, 0);

    // Zero-wait write to 0x8
    awaddr = 32'h8; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    b0 = req_cycles;
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    check("w1_aw_held", awready, 0);
    step(1);
    check("w1_req", reg_req, 1);
    check("w1_we", reg_we, 1);
    check("w1_addr", reg_addr, 2);
    check("w1_wdata", reg_wdata, 32'hDEAD_BEEF);
    check("w1_wstrb", reg_wstrb, 4'hF);
    check("w1_awready_again", awready, 1);
    step(1);
    check("w1_req_drop", reg_req, 0);
    check("w1_bvalid_early", bvalid, 0);
    step(1);
    check("w1_bvalid", bvalid, 1);
    check("w1_bresp", bresp, 0);
    check("w1_req_cycles", req_cycles - b0, 1);
    bready = 1'b1;
    step(1);
    check("w1_bvalid_clr", bvalid, 0);
    bready = 1'b0;

    // W four cycles ahead of AW, response back-pressured
    wdata = 32'h1122_3344; wstrb = 4'h3; wvalid = 1'b1;
    step(1);
    wvalid = 1'b0;
    check("w2_w_held", wready, 0);
    b0 = req_cycles;
    step(3);
    check("w2_no_req_without_aw", req_cycles - b0, 0);
    awaddr = 32'h14; awvalid = 1'b1;
    step(1);
    awvalid = 1'b0;
    step(1);
    check("w2_req", reg_req, 1);
    check("w2_addr", reg_addr, 5);
    check("w2_wstrb", reg_wstrb, 4'h3);
    check("w2_wdata", reg_wdata, 32'h1122_3344);
    awaddr = 32'h4; awvalid = 1'b1;
    check("w2_aw2_ready", awready, 1);
    step(1);
    awvalid = 1'b0;
    check("w2_aw2_held", awready, 0);
    step(1);
    for (int j = 0; j < 5; j++) begin
      check("w2_bvalid_hold", bvalid, 1);
      check("w2_bresp_hold", bresp, 0);
      if (j < 4) step(1);
    end
    bready = 1'b1;
    step(1);
    check("w2_bvalid_clr", bvalid, 0);
    check("w2_single_write", req_cycles - b0, 1);
    wdata = 32'h5566_7788; wstrb = 4'hF; wvalid = 1'b1;
    step(1);
    wvalid = 1'b0;
    step(1);
    check("w3_addr", reg_addr, 1);
    check("w3_wdata", reg_wdata, 32'h5566_7788);
    step(2);
    check("w3_bvalid", bvalid, 1);
    check("w3_bresp", bresp, 0);
    step(1);
    check("w3_bvalid_clr", bvalid, 0);
    bready = 1'b0;

    // Out-of-range read
    araddr = 32'h40; arvalid = 1'b1;
    b0 = req_cycles;
    step(1);
    arvalid = 1'b0;
    step(1);
    check("dec_rvalid_early", rvalid, 0);
    step(1);
    check("dec_rvalid", rvalid, 1);
    check("dec_rresp", rresp, 2'b11);
    check("dec_rdata", rdata, 0);
    check("dec_no_req", req_cycles - b0, 0);
    rready = 1'b1;
    step(1);
    check("dec_rvalid_clr", rvalid, 0);
    rready = 1'b0;

    // Read with no ack: timeout after 16 request cycles, late ack ignored
    ack_en = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    b0 = req_cycles;
    step(1);
    arvalid = 1'b0;
    step(1);
    check("to_req", reg_req, 1);
    check("to_we", reg_we, 0);
    check("to_addr", reg_addr, 3);
    step(15);
    check("to_req_last", reg_req, 1);
    step(1);
    check("to_req_drop", reg_req, 0);
    late_ack = 1'b1;
    step(1);
    late_ack = 1'b0;
    check("to_rvalid", rvalid, 1);
    check("to_rresp", rresp, 2'b10);
    check("to_rdata", rdata, 0);
    check("to_req_cycles", req_cycles - b0, 16);
    step(2);
    check("to_rresp_stable", {rvalid, rresp}, 3'b110);
    check("to_no_new_req", reg_req, 0);
    rready = 1'b1;
    step(1);
    check("to_rvalid_clr", rvalid, 0);
    rready = 1'b0;
    ack_en = 1'b1;

    // Simultaneous write and read streams straight after reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bready = 1'b1; rready = 1'b1;
    g0 = grant_n;
    fork
      begin : wr_master
        int k;
        for (int i = 0; i < 4; i++) begin
          awaddr = 32'(i * 8); wdata = 32'hA000_0000 + 32'(i); wstrb = 4'hF;
          awvalid = 1'b1; wvalid = 1'b1;
          k = 0;
          @(negedge clk);
          while (!(awready && wready) && k < 100) begin
            @(negedge clk);
            k++;
          end
          @(posedge clk);
          #1;
          awvalid = 1'b0; wvalid = 1'b0;
        end
      end
      begin : rd_master
        int k;
        for (int i = 0; i < 4; i++) begin
          araddr = 32'(i * 8 + 4); arvalid = 1'b1;
          k = 0;
          @(negedge clk);
          while (!arready && k < 100) begin
            @(negedge clk);
            k++;
          end
          @(posedge clk);
          #1;
          arvalid = 1'b0;
        end
      end
      begin : resp_mon
        int nb;
        int nr;
        int k;
        nb = 0; nr = 0; k = 0;
        while ((nb < 4 || nr < 4) && k < 300) begin
          @(negedge clk);
          k++;
          if (bvalid) begin
            check("rr_bresp", bresp, 0);
            nb++;
          end
          if (rvalid) begin
            check("rr_rresp", rresp, 0);
            check("rr_rdata", rdata, 32'hC0DE_0000 | 32'(2 * nr + 1));
            nr++;
          end
        end
        check("rr_num_b", nb, 4);
        check("rr_num_r", nr, 4);
      end
    join
    step(1);
    exp_order = 8'b0101_0101;
    check("rr_grant_count", grant_n - g0, 8);
    for (int j = 0; j < 8; j++) begin
      check("rr_grant_order", grant_we[6'(g0 + j)], exp_order[j]);
    end
    bready = 1'b0; rready = 1'b0;

    // Reset during a read access
    ack_en = 1'b0;
    araddr = 32'h10; arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    step(1);
    check("ra_req", reg_req, 1);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("ra_req_drop", reg_req, 0);
    check("ra_rvalid", rvalid, 0);
    check("ra_readies", {awready, wready, arready}, 3'b111);
    check("ra_reg_addr", reg_addr, 0);
    step(20);
    check("ra_abandoned", {rvalid, reg_req}, 0);
    ack_en = 1'b1;
    araddr = 32'h10; arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    step(3);
    check("ra_next_rvalid", rvalid, 1);
    check("ra_next_rresp", rresp, 0);
    check("ra_next_rdata", rdata, 32'hC0DE_0004);
    rready = 1'b1;
    step(1);
    check("ra_next_clr", rvalid, 0);
    rready = 1'b0;

    // Register-side error on a read
    err_en = 1'b1;
    araddr = 32'h18; arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    step(3);
    check("err_rvalid", rvalid, 1);
    check("err_rresp", rresp, 2'b10);
    check("err_rdata", rdata, 0);
    err_en = 1'b0;
    rready = 1'b1;
    step(1);
    rready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bridge.md
Name: axi_lite_reg_bridge

Overview:
- AXI-Lite slave that bridges AXI-Lite transactions onto a single shared register port with a req/ack handshake.
- Successor to the fixed-latency slave interface. Adds:
  - independent one-deep AW/W/AR buffering
  - round-robin read/write arbitration
  - base-address range decode with DECERR
  - wait-state support
  - an access timeout that returns SLVERR
- Sits between the system AXI-Lite interconnect and a peripheral register file, such as the UART CSR block.

Parameters:
- DATA_WIDTH, 32, AXI and register data width; must be 32 or 64.
- ADDR_WIDTH, 32, AXI address width.
- REG_ADDR_WIDTH, 4, width of the register word index.
- NUM_REGS, 16, number of implemented words; must be ≤ 2**REG_ADDR_WIDTH.
- BASE_ADDR, 0, byte base address of the register window; must be NUM_REGS*(DATA_WIDTH/8) aligned.
- TIMEOUT_CYCLES, 16, cycles to wait for reg_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  ignored
- awvalid  in  1
- awready  out  1
- wdata  in  DATA_WIDTH
- wstrb  in  DATA_WIDTH/8
- wvalid  in  1
- wready  out  1
- bresp  out  2
- bvalid  out  1
- bready  in  1
- araddr  in  ADDR_WIDTH
- arprot  in  3  ignored
- arvalid  in  1
- arready  out  1
- rdata  out  DATA_WIDTH
- rresp  out  2
- rvalid  out  1
- rready  in  1
- reg_req  out  1  access request, held until ack or timeout
- reg_we  out  1  1 = write, 0 = read
- reg_addr  out  REG_ADDR_WIDTH  word index
- reg_wdata  out  DATA_WIDTH
- reg_wstrb  out  DATA_WIDTH/8
- reg_ack  in  1  access complete; valid only while reg_req = 1
- reg_rdata  in  DATA_WIDTH  sampled when reg_ack = 1
- reg_error  in  1  sampled when reg_ack = 1; forces SLVERR

Behaviour:
- Reset (rst sampled high at posedge): all buffers empty, FSM to IDLE, arbiter pointer to WRITE.
  - Reset output values: awready = wready = arready = 1; bvalid = rvalid = reg_req = reg_we = 0; bresp = rresp = 00; rdata, reg_addr, reg_wdata, reg_wstrb = 0.
  - An in-flight access is abandoned with no AXI response; reg_req drops the cycle after rst is sampled.
- Buffers: AW, W and AR each have a one-deep holding register plus a held flag.
  - awready = !aw_held, wready = !w_held, arready = !ar_held.
  - Each is accepted independently, in any order.
  - A held flag clears on the clock edge where its transaction is granted, so the next AW/W/AR may be accepted while the access is in flight.
- Eligibility:
  - write_rdy = aw_held & w_held & !bvalid
  - read_rdy = ar_held & !rvalid
- Decode: offset = addr - BASE_ADDR; in range iff addr ≥ BASE_ADDR and offset < NUM_REGS*(DATA_WIDTH/8).
  - Word index = offset >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
- FSM states:
  - IDLE: if only one of write_rdy/read_rdy is set, grant it. If both are set, grant the side named by the pointer, then flip the pointer to the other side. Granting an out-of-range address goes directly to RESP with DECERR (11) and no reg_req. Granting an in-range address goes to ACCESS, with reg_we/addr/wdata/wstrb loaded from the buffers.
  - ACCESS: reg_req = 1; request fields held stable.
    - reg_ack = 1: go to RESP. Response is OKAY (00) if reg_error = 0, else SLVERR (10). For reads, rdata <= reg_rdata on OKAY and 0 on SLVERR.
    - Timeout: if TIMEOUT_CYCLES > 0 and the cycle counter reaches TIMEOUT_CYCLES without ack, go to RESP with SLVERR and rdata = 0. reg_req drops on the next cycle, and a late ack is ignored.
    - Counter: zeroed on ACCESS entry; width clog2(TIMEOUT_CYCLES+1).
  - RESP: one cycle. Sets bvalid (write) or rvalid (read) with its response, then returns to IDLE.
- bvalid/rvalid are held, with bresp/rresp/rdata stable, until bready/rready; they clear on the handshake edge.
  - A write and a read response may be pending simultaneously.
  - A new access of the same kind is not granted until its response has completed.
- Latency: AW+W accepted at edge 0, reg_req high in cycle 1. A zero-wait ack in cycle 1 gives bvalid high in cycle 3. Reads have identical timing.
- Simultaneous AXI handshake and grant on the same edge: the held flag refills correctly; no transaction is lost or duplicated.

Test Plan:
- Write awaddr = 0x8, wdata = 0xDEADBEEF, wstrb = 0xF, ack in the first ACCESS cycle -> reg_addr = 2, reg_we = 1, reg_req high for 1 cycle, bresp = 00; bvalid first high 3 cycles after the AW/W handshake.
- W presented 4 cycles before AW, with bready held low for 5 cycles -> a single write occurs; bvalid stays high with bresp stable until bready; a second AW is accepted (awready = 1) during that wait.
- Read araddr = 0x40 with BASE_ADDR = 0, NUM_REGS = 16 -> no reg_req; rresp = 11, rdata = 0.
- Read of a word where reg_ack never arrives, TIMEOUT_CYCLES = 16 -> reg_req high for exactly 16 cycles; rresp = 10, rdata = 0; an ack injected one cycle late is ignored.
- AW+W and AR all ready in the same cycle right after reset, repeated 4 times with zero-wait acks -> grant order W, R, W, R, W, R, W, R; all responses 00; rdata matches reg_rdata.
- Assert rst for 1 cycle during ACCESS of a read -> cycle after reset: reg_req = 0, rvalid = 0, ready outputs = 1; the next read completes normally with rresp = 00.
